// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the modulo counter family.
//   CNT_WRAP / CNT_SAT : end-of-range behaviour selectors
//   MAX_BUS            : widest packed digit bus digit_of can take
//   digit_of()         : extract digit i (w bits wide) from a packed bus
package counter_pkg;

  localparam bit CNT_WRAP = 1'b0;
  localparam bit CNT_SAT  = 1'b1;

  localparam int MAX_BUS = 256;

  function automatic logic [31:0] digit_of(input logic [MAX_BUS-1:0] bus,
                                           input int i, input int w);
    logic [MAX_BUS-1:0] sh;
    sh = bus >> (i * w);
    digit_of = sh[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/counter_modulo_digit.sv
// counter_modulo_digit: one modulo-MODULO up/down digit.
//   clk, rst   : clock, synchronous active-high reset
//   step       : advance this digit by one in the direction of up
//   up         : 1 = increment, 0 = decrement
//   load       : take ld_val (digits >= MODULO are forced to 0)
//   ld_val     : parallel load value for this digit
//   q          : current digit value
//   at_max     : q == MODULO-1
//   at_zero    : q == 0
module counter_modulo_digit #(
  parameter int MODULO = 4,
  parameter int WIDTH  = $clog2(MODULO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULO - 1);

  assign at_max  = (q == MAXV);
  assign at_zero = (q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= (int'(ld_val) >= MODULO) ? '0 : ld_val;
    end else if (step) begin
      if (up) q <= at_max  ? '0   : q + WIDTH'(1);
      else    q <= at_zero ? MAXV : q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_modulo_cascade.sv
// counter_modulo_cascade: DIGITS cascaded modulo-MODULO digits forming one
// mixed-radix up/down counter with load, wrap/saturate mode and cascade carry.
//   clk, rst  : clock, synchronous active-high reset
//   ce, up    : count enable, direction (1 = up)
//   load      : parallel load of load_val (priority over ce)
//   load_val  : digit i at bits [i*WIDTH +: WIDTH]
//   out       : current count, digit 0 least significant
//   carry     : combinational cascade carry (always 0 in saturate mode)
//   wrap      : one-cycle pulse after a roll-over step
//   sat       : level, count is pinned at end of range
//   load_err  : one-cycle pulse after a load containing an illegal digit
module counter_modulo_cascade
  import counter_pkg::*;
#(
  parameter int MODULO   = 4,
  parameter int DIGITS   = 2,
  parameter int SATURATE = 0,
  parameter int WIDTH    = $clog2(MODULO)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    up,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] load_val,
  output logic [DIGITS*WIDTH-1:0] out,
  output logic                    carry,
  output logic                    wrap,
  output logic                    sat,
  output logic                    load_err
);

  localparam bit SAT_MODE = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;

  // en[i] = every digit below i sits at its turning point for the current
  // direction; en[DIGITS] is therefore end-of-range for the whole chain.
  logic [DIGITS:0]   en;
  logic [DIGITS-1:0] at_max, at_zero, step, bad;
  logic [WIDTH-1:0]  ld_digit [DIGITS];
  logic [WIDTH-1:0]  q_digit  [DIGITS];
  logic [MAX_BUS-1:0] load_bus;
  logic eor, hold, advance;

  assign load_bus = MAX_BUS'(load_val);
  assign en[0]    = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign en[gi+1]     = en[gi] & (up ? at_max[gi] : at_zero[gi]);
      assign step[gi]     = advance & en[gi];
      assign ld_digit[gi] = WIDTH'(digit_of(load_bus, gi, WIDTH));
      assign bad[gi]      = (int'(ld_digit[gi]) >= MODULO);
      assign out[gi*WIDTH +: WIDTH] = q_digit[gi];

      counter_modulo_digit #(.MODULO(MODULO), .WIDTH(WIDTH)) u_digit (
        .clk     (clk),
        .rst     (rst),
        .step    (step[gi]),
        .up      (up),
        .load    (load),
        .ld_val  (ld_digit[gi]),
        .q       (q_digit[gi]),
        .at_max  (at_max[gi]),
        .at_zero (at_zero[gi])
      );
    end
  endgenerate

  assign eor     = en[DIGITS];
  // In saturate mode a step at end of range is suppressed entirely; reversing
  // direction clears eor for the new direction so the step goes through.
  assign hold    = SAT_MODE & eor;
  assign advance = ce & ~load & ~hold;
  // carry depends on the live up input, so a direction change at end of
  // range never shows a carry for the direction not being taken.
  assign carry   = ce & ~load & ~rst & eor & ~SAT_MODE;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap     <= 1'b0;
      sat      <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      wrap     <= 1'b0;
      sat      <= 1'b0;
      load_err <= |bad;
    end else if (ce) begin
      wrap     <= eor & ~SAT_MODE;
      sat      <= eor & SAT_MODE;
      load_err <= 1'b0;
    end else begin
      // Idle: the count does not change, so sat keeps its level.
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_modulo_cascade.sv
// tb_counter_modulo_cascade: three instances (wrap 10x2, saturate 10x2,
// wrap 4x3) checked every cycle against an integer-valued reference model.
module tb_counter_modulo_cascade;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       rst_a, ce_a, up_a, load_a, carry_a, wrap_a, sat_a, lerr_a;
  logic [7:0] lv_a, out_a;
  logic       rst_b, ce_b, up_b, load_b, carry_b, wrap_b, sat_b, lerr_b;
  logic [7:0] lv_b, out_b;
  logic       rst_c, ce_c, up_c, load_c, carry_c, wrap_c, sat_c, lerr_c;
  logic [5:0] lv_c, out_c;

  counter_modulo_cascade #(.MODULO(10), .DIGITS(2), .SATURATE(0)) u_a (
    .clk(clk), .rst(rst_a), .ce(ce_a), .up(up_a), .load(load_a),
    .load_val(lv_a), .out(out_a), .carry(carry_a), .wrap(wrap_a),
    .sat(sat_a), .load_err(lerr_a));

  counter_modulo_cascade #(.MODULO(10), .DIGITS(2), .SATURATE(1)) u_b (
    .clk(clk), .rst(rst_b), .ce(ce_b), .up(up_b), .load(load_b),
    .load_val(lv_b), .out(out_b), .carry(carry_b), .wrap(wrap_b),
    .sat(sat_b), .load_err(lerr_b));

  counter_modulo_cascade #(.MODULO(4), .DIGITS(3), .SATURATE(0)) u_c (
    .clk(clk), .rst(rst_c), .ce(ce_c), .up(up_c), .load(load_c),
    .load_val(lv_c), .out(out_c), .carry(carry_c), .wrap(wrap_c),
    .sat(sat_c), .load_err(lerr_c));

  // ---------------- stimulus state ----------------
  int mod_k [3] = '{10, 10, 4};
  int dig_k [3] = '{2, 2, 3};
  int w_k   [3] = '{4, 4, 2};
  bit satm_k[3] = '{1'b0, 1'b1, 1'b0};

  bit r_v[3], c_v[3], u_v[3], l_v[3];
  int lv_v[3];

  // ---------------- reference model ----------------
  int val[3];
  bit m_wrap[3], m_sat[3], m_lerr[3];
  logic [31:0] exp_q[$];

  int n_total = 0;
  int n_bad   = 0;

  function automatic int ipow(int b, int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  // Count value -> packed digit bus.
  function automatic logic [31:0] pack_val(int k, int v);
    logic [31:0] p = '0;
    for (int d = 0; d < dig_k[k]; d++) begin
      p = p | (32'(v % mod_k[k]) << (d * w_k[k]));
      v = v / mod_k[k];
    end
    return p;
  endfunction

  function automatic bit at_end(int k, bit dir);
    return dir ? (val[k] == ipow(mod_k[k], dig_k[k]) - 1) : (val[k] == 0);
  endfunction

  task automatic model_step(int k);
    int total, x, v;
    bit err;
    total = ipow(mod_k[k], dig_k[k]);
    if (r_v[k]) begin
      val[k] = 0; m_wrap[k] = 0; m_sat[k] = 0; m_lerr[k] = 0;
    end else if (l_v[k]) begin
      v = 0; err = 0;
      for (int d = 0; d < dig_k[k]; d++) begin
        x = (lv_v[k] >> (d * w_k[k])) & ((1 << w_k[k]) - 1);
        if (x >= mod_k[k]) begin x = 0; err = 1; end
        v = v + x * ipow(mod_k[k], d);
      end
      val[k] = v; m_wrap[k] = 0; m_sat[k] = 0; m_lerr[k] = err;
    end else if (c_v[k]) begin
      m_lerr[k] = 0;
      if (at_end(k, u_v[k])) begin
        if (satm_k[k]) begin
          m_sat[k] = 1; m_wrap[k] = 0;
        end else begin
          val[k] = u_v[k] ? 0 : total - 1;
          m_wrap[k] = 1; m_sat[k] = 0;
        end
      end else begin
        val[k] = u_v[k] ? val[k] + 1 : val[k] - 1;
        m_wrap[k] = 0; m_sat[k] = 0;
      end
    end else begin
      m_wrap[k] = 0; m_lerr[k] = 0;
    end
    exp_q.push_back(pack_val(k, val[k]));
  endtask

  // ---------------- checking ----------------
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs(int k, int which);
    logic [31:0] r;
    r = '0;
    case (k)
      0: case (which)
           0: r = 32'(out_a); 1: r = 32'(wrap_a); 2: r = 32'(sat_a);
           3: r = 32'(lerr_a); default: r = 32'(carry_a);
         endcase
      1: case (which)
           0: r = 32'(out_b); 1: r = 32'(wrap_b); 2: r = 32'(sat_b);
           3: r = 32'(lerr_b); default: r = 32'(carry_b);
         endcase
      default: case (which)
           0: r = 32'(out_c); 1: r = 32'(wrap_c); 2: r = 32'(sat_c);
           3: r = 32'(lerr_c); default: r = 32'(carry_c);
         endcase
    endcase
    return r;
  endfunction

  task automatic check_all();
    logic [31:0] e_out;
    bit e_carry;
    for (int k = 0; k < 3; k++) begin
      e_out   = exp_q.pop_front();
      e_carry = c_v[k] & ~l_v[k] & ~r_v[k] & at_end(k, u_v[k]) & ~satm_k[k];
      check($sformatf("out[%0d]", k),   obs(k, 0), e_out);
      check($sformatf("wrap[%0d]", k),  obs(k, 1), 32'(m_wrap[k]));
      check($sformatf("sat[%0d]", k),   obs(k, 2), 32'(m_sat[k]));
      check($sformatf("lerr[%0d]", k),  obs(k, 3), 32'(m_lerr[k]));
      check($sformatf("carry[%0d]", k), obs(k, 4), 32'(e_carry));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(int k, bit r, bit c, bit u, bit l, int lv);
    r_v[k] = r; c_v[k] = c; u_v[k] = u; l_v[k] = l; lv_v[k] = lv;
  endtask

  task automatic drive();
    rst_a = r_v[0]; ce_a = c_v[0]; up_a = u_v[0]; load_a = l_v[0]; lv_a = lv_v[0][7:0];
    rst_b = r_v[1]; ce_b = c_v[1]; up_b = u_v[1]; load_b = l_v[1]; lv_b = lv_v[1][7:0];
    rst_c = r_v[2]; ce_c = c_v[2]; up_c = u_v[2]; load_c = l_v[2]; lv_c = lv_v[2][5:0];
  endtask

  // Inputs change at the falling edge; outputs are compared 1 ns later,
  // well away from the rising edge that updates the DUT and the model.
  task automatic tick(bit do_check);
    drive();
    #1;
    if (do_check) check_all();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
  endtask

  // ---------------- sequence ----------------
  initial begin
    for (int k = 0; k < 3; k++) set_in(k, 1, 0, 0, 0, 0);
    @(negedge clk);
    tick(0);
    for (int k = 0; k < 3; k++) set_in(k, 0, 0, 0, 0, 0);

    // Full up-count 00..99 and roll-over to 00.
    set_in(0, 0, 1, 1, 0, 0);
    repeat (101) tick(1);

    // Load 00 then count down through the roll-over to 99, 98, ...
    set_in(0, 0, 0, 0, 1, 0);
    tick(1);
    set_in(0, 0, 1, 0, 0, 0);
    repeat (25) tick(1);
    set_in(0, 0, 0, 0, 0, 0);

    // Saturating instance: load 98, push up into the ceiling, then back off.
    set_in(1, 0, 0, 1, 1, 'h98);
    tick(1);
    set_in(1, 0, 1, 1, 0, 0);
    repeat (4) tick(1);
    set_in(1, 0, 1, 0, 0, 0);
    repeat (2) tick(1);
    // Drive down to 00 and hold at the floor.
    repeat (100) tick(1);
    set_in(1, 0, 0, 0, 0, 0);
    repeat (2) tick(1);

    // Illegal upper digit 12 with ce also high.
    set_in(0, 0, 1, 1, 1, 'hC7);
    tick(1);
    set_in(0, 0, 0, 1, 0, 0);
    repeat (2) tick(1);

    // Reset beats load and ce at 45.
    set_in(0, 0, 0, 1, 1, 'h45);
    tick(1);
    set_in(0, 1, 1, 1, 1, 'h99);
    tick(1);
    set_in(0, 0, 0, 1, 0, 0);
    repeat (2) tick(1);

    // 4x3 instance: from 333 toggle direction every cycle.
    set_in(2, 0, 0, 1, 1, 63);
    tick(1);
    for (int i = 0; i < 12; i++) begin
      set_in(2, 0, 1, (i % 2 == 0), 0, 0);
      tick(1);
    end

    // Randomized traffic on all three instances.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++) begin
        set_in(k,
               ($urandom_range(0, 63) == 0),
               ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 9) == 0),
               int'($urandom_range(0, (1 << (dig_k[k] * w_k[k])) - 1)));
      end
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
